// File: rtl/program_loader.sv
// Program loader: collects a byte stream into 14-bit instruction words, then
// serves the word addressed by the CPU program counter while running.
module program_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [7:0]        load_byte,
  input  logic              load_last,
  input  logic              reload,
  input  logic [7:0]        pc,
  output logic [13:0]       instruction,
  output logic              running,
  output logic [ADDR_W:0]   word_count,
  output logic              pc_misaligned
);

  // state   | meaning
  // LOAD_LO | waiting for the low byte of a word (reset state)
  // LOAD_HI | low byte held, waiting for the high byte
  // RUN     | serving instructions to the CPU
  typedef enum logic [1:0] {
    LOAD_LO = 2'd0,
    LOAD_HI = 2'd1,
    RUN     = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W + 1)'(DEPTH);

  state_t             r_state;
  logic [7:0]         r_lo_hold;
  logic [ADDR_W:0]    r_word_count;
  logic [13:0]        r_instruction;
  logic [13:0]        r_mem [DEPTH];

  logic               w_xfer;
  logic [ADDR_W:0]    w_count_inc;
  logic [ADDR_W-1:0]  w_idx;
  logic               w_pc_in_range;
  logic [13:0]        w_next_instr;
  logic               w_unused_hi;

  assign load_ready = (r_state != RUN) && !reload && (r_word_count < L_DEPTH);
  assign w_xfer     = load_valid && load_ready;
  assign w_count_inc = r_word_count + 1'b1;

  // pc[1:0] never take part in indexing; upper pc bits must be zero
  assign w_idx         = pc[ADDR_W+1:2];
  assign w_pc_in_range = (pc[7:ADDR_W+2] == '0) && ({1'b0, w_idx} < r_word_count);
  assign w_next_instr  = w_pc_in_range ? r_mem[w_idx] : 14'h0000;

  // the two top bits of a high byte do not fit in a 14-bit word
  assign w_unused_hi = ^load_byte[7:6];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= LOAD_LO;
      r_lo_hold     <= 8'h00;
      r_word_count  <= '0;
      r_instruction <= 14'h0000;
    end else if (reload) begin
      r_state       <= LOAD_LO;
      r_word_count  <= '0;
      r_instruction <= 14'h0000;
    end else begin
      case (r_state)
        LOAD_LO: begin
          r_instruction <= 14'h0000;
          if (w_xfer) begin
            r_lo_hold <= load_byte;
            r_state   <= LOAD_HI;
          end
        end
        LOAD_HI: begin
          r_instruction <= 14'h0000;
          if (w_xfer) begin
            r_word_count <= w_count_inc;
            if (load_last || (w_count_inc == L_DEPTH)) begin
              r_state <= RUN;
            end else begin
              r_state <= LOAD_LO;
            end
          end
        end
        RUN: begin
          r_instruction <= w_next_instr;
        end
        default: begin
          r_state       <= LOAD_LO;
          r_instruction <= 14'h0000;
        end
      endcase
    end
  end

  // storage is not reset; words at or above word_count are never served
  always_ff @(posedge clock) begin
    if (w_xfer && (r_state == LOAD_HI)) begin
      r_mem[r_word_count[ADDR_W-1:0]] <= {load_byte[5:0], r_lo_hold};
    end
  end

  assign instruction   = r_instruction;
  assign running       = (r_state == RUN);
  assign word_count    = r_word_count;
  assign pc_misaligned = (r_state == RUN) && (pc[1:0] != 2'b00);

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: a word-list model of the loader checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_program_loader;

  logic        clock;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [7:0]  load_byte;
  logic        load_last;
  logic        reload;
  logic [7:0]  pc;
  logic [13:0] instruction;
  logic        running;
  logic [4:0]  word_count;
  logic        pc_misaligned;

  int n_pass  = 0;
  int n_total = 0;

  program_loader #(.DEPTH(16), .ADDR_W(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_byte    (load_byte),
    .load_last    (load_last),
    .reload       (reload),
    .pc           (pc),
    .instruction  (instruction),
    .running      (running),
    .word_count   (word_count),
    .pc_misaligned(pc_misaligned)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Model: the program is a list of words; a pending low byte is separate.
  int          m_words [16];
  int          m_count   = 0;
  bit          m_half    = 0;
  int          m_lo      = 0;
  bit          m_running = 0;
  int          m_instr   = 0;

  function automatic int serve(input int p, input int cnt);
    if (p < 4 * cnt) return m_words[p / 4];
    return 0;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_count = 0; m_half = 0; m_lo = 0; m_running = 0; m_instr = 0;
    end else if (reload) begin
      m_count = 0; m_half = 0; m_running = 0; m_instr = 0;
    end else if (m_running) begin
      m_instr = serve(int'(pc), m_count);
    end else begin
      m_instr = 0;
      if (load_valid && m_count < 16) begin
        if (!m_half) begin
          m_lo   = int'(load_byte);
          m_half = 1;
        end else begin
          m_words[m_count] = (int'(load_byte) % 64) * 256 + m_lo;
          m_count = m_count + 1;
          m_half  = 0;
          if (load_last || m_count == 16) m_running = 1;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clock) begin
    chk("running",    int'(running),     int'(m_running));
    chk("word_count", int'(word_count),  m_count);
    chk("instr",      int'(instruction), m_instr);
    chk("load_ready", int'(load_ready),
        int'(!m_running && !reload && m_count < 16));
    chk("misaligned", int'(pc_misaligned),
        int'(m_running && (int'(pc) % 4 != 0)));
  end

  task automatic tick();
    @(negedge clock);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    load_valid = 1'b1;
    load_byte  = b;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] lo, input logic [7:0] hi,
                           input logic last, input int gap);
    send_byte(lo, 1'b0);
    repeat (gap) tick();
    send_byte(hi, last);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  task automatic step_pc(input logic [7:0] p);
    pc = p;
    tick();
  endtask

  logic [7:0] b;

  initial begin
    reset = 1'b0; load_valid = 1'b0; load_byte = 8'h00; load_last = 1'b0;
    reload = 1'b0; pc = 8'h00;
    #1 reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("lit_reset_running", int'(running), 0);
    chk("lit_reset_ready",   int'(load_ready), 1);
    chk("lit_reset_count",   int'(word_count), 0);
    chk("lit_reset_instr",   int'(instruction), 0);

    // single-word program
    send_word(8'h31, 8'h05, 1'b1, 0);
    chk("lit_one_running", int'(running), 1);
    chk("lit_one_count",   int'(word_count), 1);
    step_pc(8'h00);
    chk("lit_one_instr", int'(instruction), 'h0531);

    // three words, high byte 0xFF truncates
    pulse_reload();
    send_word(8'h01, 8'h00, 1'b0, 0);
    send_word(8'h34, 8'h12, 1'b0, 0);
    send_word(8'hFF, 8'hFF, 1'b1, 0);
    chk("lit_three_count", int'(word_count), 3);
    step_pc(8'd0);  chk("lit_pc0",  int'(instruction), 'h0001);
    step_pc(8'd4);  chk("lit_pc4",  int'(instruction), 'h1234);
    step_pc(8'd8);  chk("lit_pc8",  int'(instruction), 'h3FFF);
    step_pc(8'd12); chk("lit_pc12", int'(instruction), 'h0000);

    // fill to DEPTH without load_last
    step_pc(8'd0);
    pulse_reload();
    for (int i = 0; i < 32; i++) begin
      b = 8'((i * 7 + 3) % 256);
      send_byte(b, 1'b0);
    end
    chk("lit_full_running", int'(running), 1);
    chk("lit_full_count",   int'(word_count), 16);
    chk("lit_full_ready",   int'(load_ready), 0);
    load_valid = 1'b1; load_byte = 8'hAA;
    repeat (3) tick();
    load_valid = 1'b0;
    chk("lit_full_hold_count", int'(word_count), 16);
    for (int p = 0; p < 64; p += 4) step_pc(8'(p));
    step_pc(8'd20);
    chk("lit_full_word5", int'(instruction), 'h1049);

    // stalls between low and high bytes
    step_pc(8'd0);
    pulse_reload();
    send_word(8'h01, 8'h00, 1'b0, $urandom_range(1, 4));
    send_word(8'h34, 8'h12, 1'b0, 10);
    send_word(8'hFF, 8'hFF, 1'b1, $urandom_range(1, 4));
    step_pc(8'd0); chk("lit_stall_pc0", int'(instruction), 'h0001);
    step_pc(8'd4); chk("lit_stall_pc4", int'(instruction), 'h1234);
    step_pc(8'd8); chk("lit_stall_pc8", int'(instruction), 'h3FFF);
    step_pc(8'h05);
    chk("lit_mis_flag",  int'(pc_misaligned), 1);
    chk("lit_mis_instr", int'(instruction), 'h1234);
    step_pc(8'h80);
    chk("lit_oob_instr", int'(instruction), 0);
    step_pc(8'd4);

    // asynchronous reset while running with a live instruction
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    chk("lit_areset_running", int'(running), 0);
    chk("lit_areset_count",   int'(word_count), 0);
    chk("lit_areset_instr",   int'(instruction), 0);
    chk("lit_areset_ready",   int'(load_ready), 1);
    tick();
    reset = 1'b0;
    pc = 8'd0;
    tick();

    // half word then asynchronous reset: the held low byte is discarded
    send_byte(8'h55, 1'b0);
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    chk("lit_half_reset_ready", int'(load_ready), 1);
    tick();
    reset = 1'b0;
    tick();
    send_word(8'h22, 8'h11, 1'b1, 0);
    chk("lit_fresh_count", int'(word_count), 1);
    step_pc(8'd0);
    chk("lit_fresh_instr", int'(instruction), 'h1122);

    // reload in RUN with a coincident byte that must not be taken
    load_valid = 1'b1; load_byte = 8'h77;
    pulse_reload();
    load_valid = 1'b0;
    chk("lit_reload_running", int'(running), 0);
    chk("lit_reload_count",   int'(word_count), 0);
    chk("lit_reload_instr",   int'(instruction), 0);
    send_word(8'h0F, 8'h2A, 1'b1, 0);
    step_pc(8'd0);
    chk("lit_after_reload_instr", int'(instruction), 'h2A0F);
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
